// File: rtl/multicycle_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: states, opcodes,
// ALU-op codes, mux selects and the control output bundle.
package multicycle_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_R_WB     = 4'd7,
        S_ADDI_EX  = 4'd8,
        S_ADDI_WB  = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11
    } state_e;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_RTYPE = 3'b010;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_we;
        logic [1:0] pc_src;
        logic       ir_we;
        logic       iord;
        logic       mem_rd;
        logic       mem_wr;
        logic       reg_we;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       illegal_op;
    } ctrl_t;

    function automatic logic is_legal(input logic [5:0] op);
        return (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Combinational map from FSM state (plus opcode, zero, mem_ready) to the
// datapath control bundle. MULTICYCLE_MEM_WAIT_EN gates FETCH writes on mem_ready.
module multicycle_ctrl_decode
    import multicycle_pkg::*;
(
    input  state_e     state_i,
    input  logic [5:0] opcode_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output ctrl_t      ctrl_o
);

    logic mem_done;
`ifdef MULTICYCLE_MEM_WAIT_EN
    assign mem_done = mem_ready_i;
`else
    logic mem_ready_unused;
    assign mem_ready_unused = mem_ready_i;
    assign mem_done = 1'b1;
`endif

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_rd    = 1'b1;
                ctrl_o.ir_we     = mem_done;
                ctrl_o.pc_we     = mem_done;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.alu_op    = ALU_ADD;
                ctrl_o.pc_src    = PCSRC_ALU;
            end
            S_DECODE: begin
                // Speculatively form the branch target into ALUOut.
                ctrl_o.alu_src_b  = SRCB_IMM_SH2;
                ctrl_o.alu_op     = ALU_ADD;
                ctrl_o.illegal_op = !is_legal(opcode_i);
            end
            S_MEM_ADDR, S_ADDI_EX: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALU_ADD;
            end
            S_MEM_RD: begin
                ctrl_o.mem_rd = 1'b1;
                ctrl_o.iord   = 1'b1;
            end
            S_MEM_WB: begin
                ctrl_o.reg_we     = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                ctrl_o.mem_wr = 1'b1;
                ctrl_o.iord   = 1'b1;
            end
            S_EXEC_R: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_B;
                ctrl_o.alu_op    = ALU_RTYPE;
            end
            S_R_WB: begin
                ctrl_o.reg_we  = 1'b1;
                ctrl_o.reg_dst = 1'b1;
            end
            S_ADDI_WB: begin
                ctrl_o.reg_we = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_B;
                ctrl_o.alu_op    = ALU_SUB;
                ctrl_o.pc_src    = PCSRC_ALUOUT;
                ctrl_o.pc_we     = zero_i;
            end
            S_JUMP: begin
                ctrl_o.pc_src = PCSRC_JUMP;
                ctrl_o.pc_we  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: state register, next-state logic and reset
// gating of outputs. MULTICYCLE_MEM_WAIT_EN adds mem_ready wait states.
module multicycle_ctrl
    import multicycle_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic       ir_we,
    output logic       iord,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       reg_we,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic       illegal_op,
    output logic [3:0] state_o
);

    state_e state_q, state_d;
    ctrl_t  ctrl, ctrl_out;
    logic   mem_done;

`ifdef MULTICYCLE_MEM_WAIT_EN
    assign mem_done = mem_ready;
`else
    assign mem_done = 1'b1;
`endif

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = mem_done ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_R:         state_d = S_EXEC_R;
                    OP_ADDI:      state_d = S_ADDI_EX;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEM_ADDR: begin
                if (opcode == OP_LW)      state_d = S_MEM_RD;
                else if (opcode == OP_SW) state_d = S_MEM_WR;
                else                      state_d = S_FETCH;
            end
            S_MEM_RD:  state_d = mem_done ? S_MEM_WB : S_MEM_RD;
            S_MEM_WR:  state_d = mem_done ? S_FETCH : S_MEM_WR;
            S_EXEC_R:  state_d = S_R_WB;
            S_ADDI_EX: state_d = S_ADDI_WB;
            default:   state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    multicycle_ctrl_decode u_decode (
        .state_i     (state_q),
        .opcode_i    (opcode),
        .zero_i      (zero),
        .mem_ready_i (mem_ready),
        .ctrl_o      (ctrl)
    );

    // Outputs are forced idle during rst so a partial instruction commits nothing.
    assign ctrl_out = rst ? '0 : ctrl;
    assign state_o  = rst ? 4'(S_FETCH) : 4'(state_q);

    assign pc_we      = ctrl_out.pc_we;
    assign pc_src     = ctrl_out.pc_src;
    assign ir_we      = ctrl_out.ir_we;
    assign iord       = ctrl_out.iord;
    assign mem_rd     = ctrl_out.mem_rd;
    assign mem_wr     = ctrl_out.mem_wr;
    assign reg_we     = ctrl_out.reg_we;
    assign reg_dst    = ctrl_out.reg_dst;
    assign mem_to_reg = ctrl_out.mem_to_reg;
    assign alu_src_a  = ctrl_out.alu_src_a;
    assign alu_src_b  = ctrl_out.alu_src_b;
    assign alu_op     = ctrl_out.alu_op;
    assign illegal_op = ctrl_out.illegal_op;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-cycle expected output vectors
// are queued per instruction and compared at the falling edge.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst, zero, mem_ready;
    logic [5:0] opcode;
    logic       pc_we, ir_we, iord, mem_rd, mem_wr, reg_we, reg_dst, mem_to_reg;
    logic       alu_src_a, illegal_op;
    logic [1:0] pc_src, alu_src_b;
    logic [2:0] alu_op;
    logic [3:0] state_o;

    localparam logic [3:0] ST_FETCH = 4'd0, ST_DECODE = 4'd1, ST_MA = 4'd2,
                           ST_MRD = 4'd3, ST_MWB = 4'd4, ST_MWR = 4'd5,
                           ST_EXR = 4'd6, ST_RWB = 4'd7, ST_AEX = 4'd8,
                           ST_AWB = 4'd9, ST_BR = 4'd10, ST_J = 4'd11;

    int n_checks = 0;
    int n_fails  = 0;
    logic [20:0] exp_q[$];
    logic [20:0] obs;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_we(pc_we), .pc_src(pc_src), .ir_we(ir_we), .iord(iord),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .reg_we(reg_we), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .illegal_op(illegal_op), .state_o(state_o)
    );

    assign obs = {pc_we, pc_src, ir_we, iord, mem_rd, mem_wr, reg_we, reg_dst,
                  mem_to_reg, alu_src_a, alu_src_b, alu_op, illegal_op, state_o};

    // Reference outputs for one cycle, straight from the per-state table.
    function automatic logic [20:0] exp_out(input logic [3:0] st, input logic [5:0] op,
                                            input logic z, input logic mr);
        logic pw = 0, irw = 0, io = 0, mrd = 0, mwr = 0, rw = 0, rd = 0, m2r = 0, sa = 0, ill = 0;
        logic [1:0] ps = 0, sb = 0;
        logic [2:0] ao = 0;
        logic rdy;
`ifdef MULTICYCLE_MEM_WAIT_EN
        rdy = mr;
`else
        rdy = 1'b1;
        if (mr) rdy = 1'b1;
`endif
        case (st)
            ST_FETCH:  begin mrd = 1; irw = rdy; pw = rdy; sb = 2'b01; end
            ST_DECODE: begin
                sb = 2'b11;
                ill = !(op == 6'b000000 || op == 6'b100011 || op == 6'b101011 ||
                        op == 6'b000100 || op == 6'b001000 || op == 6'b000010);
            end
            ST_MA, ST_AEX: begin sa = 1; sb = 2'b10; end
            ST_MRD: begin mrd = 1; io = 1; end
            ST_MWB: begin rw = 1; m2r = 1; end
            ST_MWR: begin mwr = 1; io = 1; end
            ST_EXR: begin sa = 1; ao = 3'b010; end
            ST_RWB: begin rw = 1; rd = 1; end
            ST_AWB: begin rw = 1; end
            ST_BR:  begin sa = 1; ao = 3'b001; ps = 2'b01; pw = z; end
            ST_J:   begin ps = 2'b10; pw = 1; end
            default: ;
        endcase
        return {pw, ps, irw, io, mrd, mwr, rw, rd, m2r, sa, sb, ao, ill, st};
    endfunction

    // Compare one queued vector per cycle at the falling edge.
    task automatic drain(input string name);
        int cyc = 0;
        logic [20:0] e;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fails++;
                $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, obs, e);
            end
            cyc++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_instr(input string name, input logic [5:0] op, input logic z,
                             input logic [19:0] seq, input int n);
        opcode = op;
        zero   = z;
        for (int i = 0; i < n; i++)
            exp_q.push_back(exp_out(seq[4*i +: 4], op, z, mem_ready));
        drain(name);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) exp_q.push_back(21'b0);
        drain("reset");
        rst = 1'b0;
    endtask

    task automatic test_rtype();
        run_instr("rtype", 6'b000000, 1'($urandom_range(0, 1)),
                  {4'd0, ST_RWB, ST_EXR, ST_DECODE, ST_FETCH}, 4);
    endtask

    task automatic test_mem();
        run_instr("lw", 6'b100011, 1'($urandom_range(0, 1)),
                  {ST_MWB, ST_MRD, ST_MA, ST_DECODE, ST_FETCH}, 5);
        run_instr("sw", 6'b101011, 1'($urandom_range(0, 1)),
                  {4'd0, ST_MWR, ST_MA, ST_DECODE, ST_FETCH}, 4);
    endtask

    task automatic test_branch_jump();
        run_instr("beq_taken", 6'b000100, 1'b1, {8'd0, ST_BR, ST_DECODE, ST_FETCH}, 3);
        run_instr("beq_not_taken", 6'b000100, 1'b0, {8'd0, ST_BR, ST_DECODE, ST_FETCH}, 3);
        run_instr("addi", 6'b001000, 1'($urandom_range(0, 1)),
                  {4'd0, ST_AWB, ST_AEX, ST_DECODE, ST_FETCH}, 4);
        run_instr("jump", 6'b000010, 1'($urandom_range(0, 1)),
                  {8'd0, ST_J, ST_DECODE, ST_FETCH}, 3);
    endtask

    task automatic test_back_to_back_illegal();
        run_instr("illegal_a", 6'b111111, 1'b0, {12'd0, ST_DECODE, ST_FETCH}, 2);
        run_instr("illegal_b", 6'b111111, 1'b1, {12'd0, ST_DECODE, ST_FETCH}, 2);
        run_instr("illegal_c", 6'b000001, 1'b0, {12'd0, ST_DECODE, ST_FETCH}, 2);
        run_instr("after_illegal", 6'b000000, 1'b0,
                  {4'd0, ST_RWB, ST_EXR, ST_DECODE, ST_FETCH}, 4);
    endtask

    task automatic test_reset_mid_instr();
        opcode = 6'b101011;
        zero   = 1'b0;
        exp_q.push_back(exp_out(ST_FETCH, opcode, zero, mem_ready));
        exp_q.push_back(exp_out(ST_DECODE, opcode, zero, mem_ready));
        drain("rst_mid_pre");
        rst = 1'b1;
        exp_q.push_back(21'b0);
        drain("rst_mid_hold");
        rst = 1'b0;
        run_instr("rst_mid_after", 6'b101011, 1'b0,
                  {4'd0, ST_MWR, ST_MA, ST_DECODE, ST_FETCH}, 4);
    endtask

`ifdef MULTICYCLE_MEM_WAIT_EN
    task automatic test_mem_wait();
        opcode    = 6'b000000;
        zero      = 1'b0;
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) exp_q.push_back(exp_out(ST_FETCH, opcode, zero, 1'b0));
        drain("wait_fetch_stall");
        mem_ready = 1'b1;
        run_instr("wait_fetch_go", 6'b000000, 1'b0,
                  {4'd0, ST_RWB, ST_EXR, ST_DECODE, ST_FETCH}, 4);
    endtask
`else
    task automatic test_mem_wait();
        mem_ready = 1'b0;
        run_instr("ready_ignored", 6'b100011, 1'b0,
                  {ST_MWB, ST_MRD, ST_MA, ST_DECODE, ST_FETCH}, 5);
        mem_ready = 1'b1;
    endtask
`endif

    initial begin
        rst       = 1'b1;
        opcode    = 6'b000000;
        zero      = 1'b0;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_rtype();
        test_mem();
        test_branch_jump();
        test_back_to_back_illegal();
        test_reset_mid_instr();
        test_mem_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
